audio_filter_sequencer: RTL and testbench

- Time-multiplexed controller for the stereo first-order high-pass filter path.
- On each rising edge of AUD_DACLRCK it captures one 32-bit stereo ADC sample (left in [31:16], right in [15:0]).
- It runs the left channel, then the right, through a single shared serial restoring divider that computes y = 16*(y1 + x - x1)/141, keeps per-channel history, and presents the stereo result with a one-cycle valid pulse.
- It replaces the per-channel combinational divide, and sits between the ADC deserialiser and the DAC serialiser.

---
 rtl/audio_filter_sequencer.sv | 151 +++++++++++++++
 tb/tb_audio_filter_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/audio_filter_sequencer.sv
`default_nettype none
// ============================================================================
// audio_filter_sequencer: stereo first-order high-pass filter, one serial
// restoring divider shared by both channels.            Rev 1.0
// ============================================================================
module audio_filter_sequencer #(
  parameter int DIVISOR    = 141,
  parameter int GAIN_SHIFT = 4,
  parameter int DIV_BITS   = 22
) (
  input  logic        AUDIO_CLK,
  input  logic        rst,
  input  logic        AUD_DACLRCK,
  input  logic [31:0] currentADCData,
  input  logic        filter_en,
  output logic [31:0] filterOutput,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int c_SUM_W = DIV_BITS + 1 - GAIN_SHIFT;
  localparam int c_REM_W = $clog2(DIVISOR);
  localparam int c_CNT_W = $clog2(DIV_BITS);
  localparam logic [c_REM_W:0]   c_DIV_EXT  = (c_REM_W + 1)'(DIVISOR);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DIV_BITS - 1);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LOAD_L  = 3'd1;
  localparam logic [2:0] c_DIV_L   = 3'd2;
  localparam logic [2:0] c_STORE_L = 3'd3;
  localparam logic [2:0] c_LOAD_R  = 3'd4;
  localparam logic [2:0] c_DIV_R   = 3'd5;
  localparam logic [2:0] c_STORE_R = 3'd6;
  localparam logic [2:0] c_DONE    = 3'd7;

  logic [2:0]          r_state;
  logic                r_lrck_q;
  logic [31:0]         r_x;
  logic                r_en;
  logic [15:0]         r_x1_l, r_x1_r, r_y1_l, r_y1_r;
  logic [c_REM_W-1:0]  r_rem;
  logic [DIV_BITS-1:0] r_dvd;
  logic                r_neg;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [31:0]         r_out;
  logic                r_valid, r_busy, r_overrun;

  logic                w_edge, w_right, w_fits;
  logic [15:0]         w_x, w_x1, w_y1, w_q16, w_res;
  logic [c_SUM_W-1:0]  w_sum;
  logic [DIV_BITS:0]   w_prod;
  logic [DIV_BITS-1:0] w_mag;
  logic [c_REM_W:0]    w_trial;

  assign w_edge  = AUD_DACLRCK & ~r_lrck_q;
  assign w_right = (r_state == c_LOAD_R) || (r_state == c_DIV_R) || (r_state == c_STORE_R);

  always_comb begin
    w_x   = w_right ? r_x[15:0] : r_x[31:16];
    w_x1  = w_right ? r_x1_r : r_x1_l;
    w_y1  = w_right ? r_y1_r : r_y1_l;
    // |s| stays below 2^17, so the sum is kept just wide enough that the
    // gain shift lands exactly on a signed DIV_BITS+1 product.
    w_sum = {{(c_SUM_W-16){w_y1[15]}}, w_y1}
          + {{(c_SUM_W-16){w_x[15]}},  w_x}
          - {{(c_SUM_W-16){w_x1[15]}}, w_x1};
    w_prod  = {w_sum, {GAIN_SHIFT{1'b0}}};
    w_mag   = w_prod[DIV_BITS] ? (~w_prod[DIV_BITS-1:0] + DIV_BITS'(1))
                               : w_prod[DIV_BITS-1:0];
    w_trial = {r_rem, r_dvd[DIV_BITS-1]};
    w_fits  = (w_trial >= c_DIV_EXT);
    // Only the low 16 quotient bits survive, so negate in 16 bits.
    w_q16   = r_neg ? (~r_dvd[15:0] + 16'd1) : r_dvd[15:0];
    w_res   = r_en ? w_q16 : w_x;
  end

  always_ff @(posedge AUDIO_CLK) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_lrck_q  <= 1'b0;
      r_x       <= '0;
      r_en      <= 1'b0;
      r_x1_l    <= '0;
      r_x1_r    <= '0;
      r_y1_l    <= '0;
      r_y1_r    <= '0;
      r_rem     <= '0;
      r_dvd     <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_lrck_q <= AUD_DACLRCK;
      r_valid  <= 1'b0;
      if (w_edge && (r_state != c_IDLE))
        r_overrun <= 1'b1;
      case (r_state)
        c_IDLE: begin
          if (w_edge) begin
            r_x     <= currentADCData;
            r_en    <= filter_en;
            r_busy  <= 1'b1;
            r_state <= c_LOAD_L;
          end
        end
        c_LOAD_L, c_LOAD_R: begin
          r_rem   <= '0;
          r_cnt   <= '0;
          r_neg   <= w_prod[DIV_BITS];
          r_dvd   <= w_mag;
          r_state <= (r_state == c_LOAD_L) ? c_DIV_L : c_DIV_R;
        end
        c_DIV_L, c_DIV_R: begin
          r_rem <= c_REM_W'(w_trial - (w_fits ? c_DIV_EXT : '0));
          r_dvd <= {r_dvd[DIV_BITS-2:0], w_fits};
          r_cnt <= r_cnt + c_CNT_W'(1);
          if (r_cnt == c_CNT_LAST)
            r_state <= (r_state == c_DIV_L) ? c_STORE_L : c_STORE_R;
        end
        c_STORE_L: begin
          r_x1_l  <= w_x;
          r_y1_l  <= w_res;
          r_state <= c_LOAD_R;
        end
        c_STORE_R: begin
          r_x1_r  <= w_x;
          r_y1_r  <= w_res;
          r_state <= c_DONE;
        end
        c_DONE: begin
          r_out   <= {r_y1_l, r_y1_r};
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign filterOutput = r_out;
  assign out_valid    = r_valid;
  assign busy         = r_busy;
  assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_audio_filter_sequencer.sv
`default_nettype none
// Directed bench for audio_filter_sequencer; expected results are hand-computed.
module tb_audio_filter_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        lrck;
  logic [31:0] data;
  logic        en;
  logic [31:0] fout;
  logic        vld, bsy, ovr;

  int n_cmp = 0;
  int n_err = 0;

  audio_filter_sequencer dut (
    .AUDIO_CLK      (clk),
    .rst            (rst),
    .AUD_DACLRCK    (lrck),
    .currentADCData (data),
    .filter_en      (en),
    .filterOutput   (fout),
    .out_valid      (vld),
    .busy           (bsy),
    .overrun        (ovr)
  );

  always #5 clk = ~clk;

  // Drives one frame and records what the DUT did; tests judge the record.
  task automatic run_frame(input logic [31:0] d, input logic e, input int hold,
                           input int extra_at, output int vcount, output int vfirst,
                           output int busy_bad, output logic [31:0] res,
                           output logic [31:0] held);
    @(negedge clk);
    data = d; en = e; lrck = 1'b1;
    @(posedge clk); #1;
    vcount = 0; vfirst = -1; res = 'x;
    busy_bad = (bsy !== 1'b1) ? 1 : 0;
    for (int k = 1; k <= 49; k++) begin
      @(negedge clk);
      lrck = (k < hold) || (k == extra_at);
      if (k == 3) data = ~d;
      @(posedge clk); #1;
      if (vld === 1'b1) begin
        vcount++;
        if (vfirst < 0) begin
          vfirst = k;
          res = fout;
        end
      end
      if (bsy !== (k < 49)) busy_bad++;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      lrck = 1'b0;
      @(posedge clk); #1;
      if (vld !== 1'b0) vcount++;
      if (bsy !== 1'b0) busy_bad++;
    end
    held = fout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      lrck = ~lrck;
      @(posedge clk); #1;
      n_cmp++;
      if ({fout, vld, bsy, ovr} !== 35'd0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: got fout=%h vld=%b busy=%b ovr=%b, want all zero",
                 i, fout, vld, bsy, ovr);
      end
    end
    @(negedge clk);
    rst = 1'b0; lrck = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bsy !== 1'b0 || vld !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy=%b vld=%b, want 0 0", bsy, vld);
    end
  endtask

  task automatic check_frame(input string name, input int vcount, input int vfirst,
                             input int busy_bad, input logic [31:0] res,
                             input logic [31:0] held, input logic [31:0] exp);
    n_cmp++;
    if (vcount !== 1) begin
      n_err++;
      $display("FAIL %s valid_count: got %0d, want 1", name, vcount);
    end
    n_cmp++;
    if (vfirst !== 49) begin
      n_err++;
      $display("FAIL %s valid_latency: got %0d, want 49", name, vfirst);
    end
    n_cmp++;
    if (busy_bad !== 0) begin
      n_err++;
      $display("FAIL %s busy_profile: got %0d bad cycles, want 0", name, busy_bad);
    end
    n_cmp++;
    if (res !== exp) begin
      n_err++;
      $display("FAIL %s result: got %h, want %h", name, res, exp);
    end
    n_cmp++;
    if (held !== exp) begin
      n_err++;
      $display("FAIL %s output_hold: got %h, want %h", name, held, exp);
    end
  endtask

  task automatic test_first_sample();
    int vc, vf, bb; logic [31:0] r, h;
    // Level held high for 19 cycles must not retrigger or flag overrun.
    run_frame(32'h1000F000, 1'b1, 20, 0, vc, vf, bb, r, h);
    check_frame("first_sample", vc, vf, bb, r, h, 32'h01D0FE30);
    n_cmp++;
    if (ovr !== 1'b0) begin
      n_err++;
      $display("FAIL first_sample_no_overrun: got %b, want 0", ovr);
    end
  endtask

  task automatic test_second_sample();
    int vc, vf, bb; logic [31:0] r, h;
    run_frame(32'h1000F000, 1'b1, 1, 0, vc, vf, bb, r, h);
    check_frame("second_sample", vc, vf, bb, r, h, 32'h0034FFCC);
  endtask

  task automatic test_overrun();
    int vc, vf, bb; logic [31:0] r, h;
    // History y1 = +52/-52, x1 = x: s = +52/-52 -> 832/141 = 5.
    run_frame(32'h1000F000, 1'b1, 1, 10, vc, vf, bb, r, h);
    check_frame("overrun_frame", vc, vf, bb, r, h, 32'h0005FFFB);
    n_cmp++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_flag: got %b, want 1", ovr);
    end
  endtask

  task automatic test_bypass();
    int vc, vf, bb; logic [31:0] r, h;
    run_frame(32'h12345678, 1'b0, 1, 0, vc, vf, bb, r, h);
    check_frame("bypass", vc, vf, bb, r, h, 32'h12345678);
    // y1 = x1 = x, so s = x: 16*0x1234/141 = 528, 16*0x5678/141 = 2511.
    run_frame(32'h12345678, 1'b1, 1, 0, vc, vf, bb, r, h);
    check_frame("after_bypass", vc, vf, bb, r, h, 32'h021009CF);
    n_cmp++;
    if (ovr !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_sticky: got %b, want 1", ovr);
    end
  endtask

  task automatic test_reset_mid_frame();
    int vc, vf, bb, stray; logic [31:0] r, h;
    @(negedge clk);
    data = 32'h1000F000; en = 1'b1; lrck = 1'b1;
    @(posedge clk);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      lrck = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({fout, vld, bsy, ovr} !== 35'd0) begin
      n_err++;
      $display("FAIL reset_mid_frame_outputs: got fout=%h vld=%b busy=%b ovr=%b, want all zero",
               fout, vld, bsy, ovr);
    end
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (vld !== 1'b0 || bsy !== 1'b0) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL reset_mid_frame_aborted: got %0d active cycles, want 0", stray);
    end
    run_frame(32'h1000F000, 1'b1, 1, 0, vc, vf, bb, r, h);
    check_frame("after_mid_reset", vc, vf, bb, r, h, 32'h01D0FE30);
  endtask

  initial begin
    rst = 1'b1; lrck = 1'b0; data = '0; en = 1'b1;
    test_reset();
    test_first_sample();
    test_second_sample();
    test_overrun();
    test_bypass();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
